sprite_blitter: RTL

Parametrised sprite plotter for the game's VGA path. It scans an SPR_W x SPR_H monochrome bitmap row-major and emits one pixel per clock to the vga_adapter plot port (plot_en, x, y, colour). It optionally erases the sprite's previous position with a background colour before drawing the new one. It replaces the fixed 5x5 control/data/counter trio, and one instance serves each moving sprite: pacman and each ghost.

---
 rtl/sprite_blitter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: scans an SPR_W x SPR_H monochrome bitmap row-major and emits
// one pixel per clock to a VGA plot port, optionally erasing the previous
// sprite position first.
// Optional feature macro: SPRITE_BLITTER_ERASE_EN (erase phase and the storage
// of the previous origin). Without it every draw goes LOAD -> DRAW.
module sprite_blitter #(
    parameter int unsigned SPR_W = 5,
    parameter int unsigned SPR_H = 5,
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned COL_W = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic [X_W-1:0]         x_cell,
    input  logic [Y_W-1:0]         y_cell,
    input  logic [SPR_W*SPR_H-1:0] shape,
    input  logic [COL_W-1:0]       colour,
    input  logic [COL_W-1:0]       bg_colour,
    input  logic                   opaque,
    output logic                   busy,
    output logic                   done,
    output logic                   plot_en,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COL_W-1:0]       colour_out
);

    localparam int unsigned N  = SPR_W * SPR_H;
    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
`ifdef SPRITE_BLITTER_ERASE_EN
        S_ERASE = 3'd2,
`endif
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [X_W-1:0]   r_x0;
    logic [Y_W-1:0]   r_y0;
    logic [N-1:0]     r_shape;
    logic [COL_W-1:0] r_colour;
    logic [COL_W-1:0] r_bg;
    logic             r_opaque;

`ifdef SPRITE_BLITTER_ERASE_EN
    logic [X_W-1:0]   r_px0;
    logic [Y_W-1:0]   r_py0;
    logic             r_prev_valid;
`endif

    logic             w_col_last;
    logic             w_row_last;
    logic             w_last;
    logic             w_scan;

    assign w_col_last = (r_col == CW'(SPR_W - 1));
    assign w_row_last = (r_row == RW'(SPR_H - 1));
    assign w_last     = w_col_last && w_row_last;

`ifdef SPRITE_BLITTER_ERASE_EN
    assign w_scan = (r_state == S_DRAW) || (r_state == S_ERASE);
`else
    assign w_scan = (r_state == S_DRAW);
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and pixel output decode from registered state only
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        plot_en      = 1'b0;
        x            = '0;
        y            = '0;
        colour_out   = '0;
        case (r_state)
            S_IDLE: begin
                if (go) w_state_next = S_LOAD;
            end
            S_LOAD: begin
`ifdef SPRITE_BLITTER_ERASE_EN
                w_state_next = r_prev_valid ? S_ERASE : S_DRAW;
`else
                w_state_next = S_DRAW;
`endif
            end
`ifdef SPRITE_BLITTER_ERASE_EN
            S_ERASE: begin
                plot_en    = 1'b1;
                x          = r_px0 + X_W'(r_col);
                y          = r_py0 + Y_W'(r_row);
                colour_out = r_bg;
                if (w_last) w_state_next = S_DRAW;
            end
`endif
            S_DRAW: begin
                // MSB of the shifting bitmap is always the current pixel
                plot_en    = r_shape[N-1] | r_opaque;
                x          = r_x0 + X_W'(r_col);
                y          = r_y0 + Y_W'(r_row);
                colour_out = r_shape[N-1] ? r_colour : r_bg;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Row-major scan counters; idle at zero so each scan phase starts at (0,0)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (!w_scan) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
            r_col <= r_col + CW'(1);
        end
    end

    // Request latches; the bitmap shifts left once per drawn pixel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_shape  <= '0;
            r_colour <= '0;
            r_bg     <= '0;
            r_opaque <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_x0     <= x_cell * X_W'(SPR_W);
            r_y0     <= y_cell * Y_W'(SPR_H);
            r_shape  <= shape;
            r_colour <= colour;
            r_bg     <= bg_colour;
            r_opaque <= opaque;
        end else if (r_state == S_DRAW) begin
            r_shape  <= r_shape << 1;
        end
    end

`ifdef SPRITE_BLITTER_ERASE_EN
    // Remember the completed sprite origin for the next erase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_px0        <= '0;
            r_py0        <= '0;
            r_prev_valid <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_px0        <= r_x0;
            r_py0        <= r_y0;
            r_prev_valid <= 1'b1;
        end
    end
`endif

endmodule
